beam_delay_bank: RTL and testbench

BEAM_DELAY_BANK -- requirements
Module: beam_delay_bank

---
 rtl/beam_delay_bank.sv | 147 ++++++++++++++
 tb/tb_beam_delay_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/beam_delay_bank.sv
// beam_delay_bank
//   Per-channel programmable sample delay for a microphone beamformer.
//   Every channel keeps a circular history of MAX_DELAY samples behind one
//   shared write pointer. On each input strobe, channel k returns the sample
//   received d_k strobes earlier. New delays are staged in shadow registers
//   and then committed as a set. The commit waits for a cycle with no input
//   strobe, so no sample ever sees a mix of old and new delays.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous reset, active low
//   in_valid   : one-cycle strobe, new sample set on in_data
//   in_data    : packed samples, channel k at [k*DATA_W +: DATA_W]
//   out_valid  : one-cycle strobe, registered one cycle after in_valid
//   out_data   : packed delayed samples, held between strobes
//   cfg_valid  : write request for shadow[cfg_ch] <= cfg_delay
//   cfg_ready  : high while writes and commits are accepted (FSM idle)
//   cfg_ch     : channel targeted by the write
//   cfg_delay  : requested delay in samples (clamped to MAX_DELAY-1)
//   cfg_commit : copy all shadow delays into the active delays
//   cfg_err    : one-cycle pulse for a clamped or rejected write
module beam_delay_bank #(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 19,
  parameter int MAX_DELAY = 32,
  localparam int CH_W     = $clog2(NUM_CH),
  localparam int DLY_W    = $clog2(MAX_DELAY)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [DLY_W:0]           cfg_delay,
  input  logic                     cfg_commit,
  output logic                     cfg_err
);

  localparam logic [DLY_W-1:0] LAST_IDX = DLY_W'(MAX_DELAY - 1);
  localparam logic [DLY_W:0]   DEPTH    = (DLY_W+1)'(MAX_DELAY);
  localparam logic [CH_W:0]    CH_COUNT = (CH_W+1)'(NUM_CH);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                   state_q, state_d;
  logic                     do_swap;
  logic                     wr_accept, bad_ch, too_big;
  logic [DATA_W-1:0]        hist [NUM_CH][MAX_DELAY];
  logic [DLY_W-1:0]         wr_ptr, fill;
  logic [DLY_W-1:0]         shadow [NUM_CH];
  logic [DLY_W-1:0]         active [NUM_CH];
  logic [DLY_W:0]           rd_addr [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] tap;

  assign cfg_ready = (state_q == IDLE);
  assign wr_accept = cfg_valid && cfg_ready;
  assign bad_ch    = ({1'b0, cfg_ch} >= CH_COUNT);
  assign too_big   = (cfg_delay > {1'b0, LAST_IDX});

  // Tap selection. The history is read before this strobe's write lands, so
  // slot (wr_ptr - d) still holds the sample from d strobes ago. Delay 0
  // bypasses the history entirely. A delay larger than the fill count
  // points at a slot never written since reset, so it reads as zero.
  always_comb begin
    tap = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rd_addr[k] = {1'b0, wr_ptr} + DEPTH - {1'b0, active[k]};
      if (rd_addr[k] >= DEPTH) rd_addr[k] = rd_addr[k] - DEPTH;
      if (active[k] == '0)
        tap[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
      else if (active[k] <= fill)
        tap[k*DATA_W +: DATA_W] = hist[k][rd_addr[k][DLY_W-1:0]];
    end
  end

  // History storage. It is deliberately not reset: the fill counter masks
  // stale entries, so clearing the storage would only cost logic.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int k = 0; k < NUM_CH; k++)
        hist[k][wr_ptr] <= in_data[k*DATA_W +: DATA_W];
    end
  end

  // Sample path. The output is registered and holds between strobes. The
  // write pointer wraps explicitly, so MAX_DELAY need not be a power of two.
  // The fill count saturates at MAX_DELAY-1, which is the largest legal delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= tap;
        wr_ptr   <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + DLY_W'(1);
        if (fill != LAST_IDX) fill <= fill + DLY_W'(1);
      end
    end
  end

  // Configuration registers. A write in the same cycle as a commit lands in
  // the shadow set before the swap, because the swap needs at least one more
  // edge. Reset abandons any pending commit and zeroes both delay sets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cfg_err <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cfg_err <= wr_accept && (bad_ch || too_big);
      if (wr_accept && !bad_ch)
        shadow[cfg_ch] <= too_big ? LAST_IDX : cfg_delay[DLY_W-1:0];
      if (do_swap) begin
        for (int k = 0; k < NUM_CH; k++)
          active[k] <= shadow[k];
      end
    end
  end

  // Commit controller. PENDING holds off the swap until an edge with no
  // input strobe. Any sample strobed at the commit or while pending therefore
  // uses the old delays, and the next one uses the new delays.
  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      IDLE:    if (cfg_commit) state_d = PENDING;
      PENDING: if (!in_valid) begin
                 state_d = IDLE;
                 do_swap = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_beam_delay_bank.sv
// tb_beam_delay_bank
//   Drives beam_delay_bank with directed scenarios and then randomized
//   traffic. It compares every cycle against a reference model that stores
//   all samples since reset in a queue and applies the delay rules directly.
//   Six channels are used so that out-of-range channel numbers are
//   representable on cfg_ch.
module tb_beam_delay_bank;

  localparam int NCH = 6;
  localparam int DW  = 19;
  localparam int MD  = 32;
  localparam int W   = NCH * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [2:0]   cfg_ch = '0;
  logic [5:0]   cfg_delay = '0;
  logic         cfg_commit = 1'b0;
  logic         cfg_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [W-1:0] hist_q [$];
  int           m_shadow [NCH];
  int           m_active [NCH];
  bit           m_pending;
  bit           m_valid;
  bit           m_err;
  logic [W-1:0] m_out;

  beam_delay_bank #(.NUM_CH(NCH), .DATA_W(DW), .MAX_DELAY(MD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .cfg_commit(cfg_commit), .cfg_err(cfg_err)
  );

  // Free-running clock with a rising edge at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the DUT disagrees with the model.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
    end
  endtask

  // Builds a sample set where channel k carries base + step*k.
  function automatic logic [W-1:0] make_word(input int base, input int step);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < NCH; k++) w[k*DW +: DW] = DW'(base + step * k);
    return w;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < NCH; k++) w[k*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  // Output for the strobe numbered n = hist_q.size() since reset. Delay 0
  // returns the current sample. Otherwise it is the sample from strobe n-d,
  // or zero when that strobe never happened.
  function automatic logic [W-1:0] predict(input logic [W-1:0] cur);
    logic [W-1:0] res, old;
    int n, d;
    res = '0;
    n = hist_q.size();
    for (int k = 0; k < NCH; k++) begin
      d = m_active[k];
      if (d == 0) res[k*DW +: DW] = cur[k*DW +: DW];
      else if (d <= n) begin
        old = hist_q[n-d];
        res[k*DW +: DW] = old[k*DW +: DW];
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    for (int k = 0; k < NCH; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    m_pending = 1'b0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_out     = '0;
  endtask

  // Applies one cycle of inputs, advances the model across the edge and then
  // checks all outputs 1 time unit after the edge.
  task automatic applyStimulus(input logic iv, input logic [W-1:0] d,
                               input logic cv, input logic [2:0] ch,
                               input logic [5:0] dly, input logic cm,
                               input logic r, input string tag);
    bit ready;
    rst = r; in_valid = iv; in_data = d;
    cfg_valid = cv; cfg_ch = ch; cfg_delay = dly; cfg_commit = cm;
    @(posedge clk);
    if (!r) model_reset();
    else begin
      ready = !m_pending;
      m_err = 1'b0;
      m_valid = iv;
      if (iv) begin
        m_out = predict(d);
        hist_q.push_back(d);
      end
      if (cv && ready) begin
        if (int'(ch) >= NCH) m_err = 1'b1;
        else if (int'(dly) > MD - 1) begin
          m_shadow[ch] = MD - 1;
          m_err = 1'b1;
        end else m_shadow[ch] = int'(dly);
      end
      if (!m_pending) begin
        if (cm) m_pending = 1'b1;
      end else if (!iv) begin
        m_active = m_shadow;
        m_pending = 1'b0;
      end
    end
    #1;
    checkOutput({tag, ".out_valid"}, 128'(out_valid), 128'(m_valid));
    checkOutput({tag, ".out_data"},  128'(out_data),  128'(m_out));
    checkOutput({tag, ".cfg_ready"}, 128'(cfg_ready), 128'(!m_pending));
    checkOutput({tag, ".cfg_err"},   128'(cfg_err),   128'(m_err));
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, '0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1, tag);
  endtask

  task automatic strobe(input logic [W-1:0] d, input string tag);
    applyStimulus(1'b1, d, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1, tag);
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [5:0] dly,
                           input logic cm, input string tag);
    applyStimulus(1'b0, '0, 1'b1, ch, dly, cm, 1'b1, tag);
  endtask

  task automatic do_reset(input string tag);
    applyStimulus(1'b0, '0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, tag);
    applyStimulus(1'b0, '0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, tag);
  endtask

  // Directed scenarios first, then randomized traffic with occasional resets.
  initial begin
    model_reset();
    do_reset("reset");

    // All delays zero: one strobe echoes through, then the output holds.
    idle("echo.pre");
    strobe(make_word(1, 1), "echo");
    idle("echo.hold");
    idle("echo.hold2");

    // Channel 3 at delay 5, written in the same cycle as the commit, on ramp input.
    do_reset("ramp.rst");
    write_cfg(3'd3, 6'd5, 1'b1, "ramp.cfg");
    idle("ramp.swap");
    for (int i = 1; i <= 10; i++) strobe(make_word(i, 1000), "ramp");

    // Clamp of an oversize delay and rejection of out-of-range channels.
    write_cfg(3'd2, 6'd40, 1'b0, "clamp");
    write_cfg(3'd6, 6'd7, 1'b0, "badch6");
    write_cfg(3'd7, 6'd1, 1'b0, "badch7");
    write_cfg(3'd0, 6'd0, 1'b1, "clamp.commit");
    idle("clamp.swap");
    for (int i = 0; i < 34; i++) strobe(rand_word(), "clamp.run");

    // A commit in the same cycle as a strobe: that sample keeps the old delays.
    write_cfg(3'd1, 6'd2, 1'b0, "same.cfg");
    applyStimulus(1'b1, rand_word(), 1'b0, 3'd0, 6'd0, 1'b1, 1'b1, "same.commit");
    applyStimulus(1'b1, rand_word(), 1'b1, 3'd4, 6'd9, 1'b1, 1'b1, "same.ignored");
    idle("same.swap");
    strobe(rand_word(), "same.new");
    strobe(rand_word(), "same.new2");

    // Maximum delay on every channel across several pointer wraps.
    do_reset("wrap.rst");
    for (int k = 0; k < NCH; k++) write_cfg(3'(k), 6'd31, 1'b0, "wrap.cfg");
    write_cfg(3'd0, 6'd31, 1'b1, "wrap.commit");
    idle("wrap.swap");
    for (int i = 0; i < 70; i++) strobe(rand_word(), "wrap");

    // Reset while a commit is pending abandons it, and delays return to zero.
    write_cfg(3'd0, 6'd4, 1'b0, "rstpend.cfg");
    applyStimulus(1'b1, rand_word(), 1'b0, 3'd0, 6'd0, 1'b1, 1'b1, "rstpend.commit");
    strobe(rand_word(), "rstpend.hold");
    applyStimulus(1'b1, rand_word(), 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, "rstpend.rst");
    for (int i = 0; i < 4; i++) strobe(rand_word(), "rstpend.after");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, rand_word(),
                    $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                    6'($urandom_range(0, 40)), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 199) != 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
